// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the M-extension issue controller: ALU codes,
// FSM state encoding, the cache tag payload and small helpers.
package mdu_issue_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ALU_CODE_W = 6;
  localparam int unsigned RD_W       = 5;

  // Shared ALU operation codes (non-M example plus the eight M codes)
  localparam logic [ALU_CODE_W-1:0] ALU_ADD    = 6'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_MUL    = 6'd16;
  localparam logic [ALU_CODE_W-1:0] ALU_MULH   = 6'd17;
  localparam logic [ALU_CODE_W-1:0] ALU_MULHSU = 6'd18;
  localparam logic [ALU_CODE_W-1:0] ALU_MULHU  = 6'd19;
  localparam logic [ALU_CODE_W-1:0] ALU_DIV    = 6'd20;
  localparam logic [ALU_CODE_W-1:0] ALU_DIVU   = 6'd21;
  localparam logic [ALU_CODE_W-1:0] ALU_REM    = 6'd22;
  localparam logic [ALU_CODE_W-1:0] ALU_REMU   = 6'd23;

  // Controller state encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Operation identity used as the result-cache tag
  typedef struct packed {
    logic [ALU_CODE_W-1:0] code;
    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
  } mdu_tag_t;

  // True for the eight multiply/divide operation codes
  function automatic logic is_mext(input logic [ALU_CODE_W-1:0] alucode);
    case (alucode)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: is_mext = 1'b1;
      default:                              is_mext = 1'b0;
    endcase
  endfunction

  // Watchdog timer width able to hold 0..timeout
  function automatic int unsigned timer_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mdu_op_cache.sv
// One-entry cache of the last completed operation: tag compare plus data.
module mdu_op_cache
  import mdu_issue_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  mdu_tag_t        wr_tag,
  input  logic [XLEN-1:0] wr_data,
  input  mdu_tag_t        lookup_tag,
  output logic            hit_c,
  output logic [XLEN-1:0] data
);

  logic     valid;
  mdu_tag_t tag;

  // Capture tag and result of each completed operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end
  end

  assign hit_c = valid && (tag == lookup_tag);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue/sequencing controller for the multi-cycle M-extension ALU.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ALU_CODE_W-1:0] req_alucode,
  input  logic [XLEN-1:0]       req_op1,
  input  logic [XLEN-1:0]       req_op2,
  input  logic [RD_W-1:0]       req_rd,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_data,
  output logic [RD_W-1:0]       resp_rd,
  output logic                  alu_start,
  output logic [ALU_CODE_W-1:0] alu_code,
  output logic [XLEN-1:0]       alu_op1,
  output logic [XLEN-1:0]       alu_op2,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_done,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  bad_op_err,
  output logic [31:0]           ops_issued,
  output logic [31:0]           cache_hits
);

  localparam int unsigned        TIMER_W    = timer_w(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  mdu_tag_t           op;
  mdu_tag_t           req_tag;
  logic [RD_W-1:0]    rd_q;
  logic [TIMER_W-1:0] timer;
  logic [XLEN-1:0]    cache_data;
  logic               cache_match_c;
  logic               cache_hit_c;
  logic               latch_c;
  logic               bad_c;
  logic               hit_c;
  logic               launch_c;
  logic               tick_c;
  logic               done_c;
  logic               tout_c;

  assign req_tag     = '{code: req_alucode, op1: req_op1, op2: req_op2};
  assign cache_hit_c = CACHE_EN & cache_match_c;

  // Flush masks the handshake and launch strobes in the same cycle
  assign req_ready  = (state == S_IDLE)   & ~flush;
  assign alu_start  = (state == S_LAUNCH) & ~flush;
  assign resp_valid = (state == S_RESP)   & ~flush;
  assign busy       = (state != S_IDLE);
  assign alu_code   = op.code;
  assign alu_op1    = op.op1;
  assign alu_op2    = op.op2;
  assign resp_rd    = rd_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle datapath strobes
  always_comb begin
    state_nxt = state;
    latch_c   = 1'b0;
    bad_c     = 1'b0;
    hit_c     = 1'b0;
    launch_c  = 1'b0;
    tick_c    = 1'b0;
    done_c    = 1'b0;
    tout_c    = 1'b0;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (is_mext(req_alucode)) begin
              latch_c = 1'b1;
              if (cache_hit_c) begin
                hit_c     = 1'b1;
                state_nxt = S_RESP;
              end else begin
                state_nxt = S_LAUNCH;
              end
            end else begin
              bad_c = 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          launch_c  = 1'b1;
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            done_c    = 1'b1;
            state_nxt = S_RESP;
          end else if (timer == TIMER_LAST) begin
            tout_c    = 1'b1;
            state_nxt = S_RESP;
          end else begin
            tick_c = 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Latched operation, response, watchdog timer, sticky errors and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op          <= '0;
      rd_q        <= '0;
      timer       <= '0;
      resp_data   <= '0;
      ops_issued  <= '0;
      cache_hits  <= '0;
      timeout_err <= 1'b0;
      bad_op_err  <= 1'b0;
    end else begin
      if (latch_c) begin
        op   <= req_tag;
        rd_q <= req_rd;
      end
      if (bad_c) bad_op_err <= 1'b1;
      if (hit_c) begin
        resp_data  <= cache_data;
        cache_hits <= cache_hits + 32'd1;
      end
      if (launch_c) begin
        ops_issued <= ops_issued + 32'd1;
        timer      <= '0;
      end
      if (tick_c) timer <= timer + TIMER_W'(1);
      if (done_c) resp_data <= alu_result;
      if (tout_c) begin
        resp_data   <= '0;
        timeout_err <= 1'b1;
      end
    end
  end

  // Only a genuine ALU completion refreshes the cache
  mdu_op_cache u_cache (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (done_c),
    .wr_tag     (op),
    .wr_data    (alu_result),
    .lookup_tag (req_tag),
    .hit_c      (cache_match_c),
    .data       (cache_data)
  );

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: behavioural ALU, transaction-level model,
// per-cycle output compare and directed vectors with literal expectations.
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_alucode;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        alu_start;
  logic [5:0]  alu_code;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_result;
  logic        alu_done;
  logic        busy;
  logic        timeout_err;
  logic        bad_op_err;
  logic [31:0] ops_issued;
  logic [31:0] cache_hits;

  mdu_issue_ctrl #(.TIMEOUT(TMO), .CACHE_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_alucode(req_alucode),
    .req_op1(req_op1), .req_op2(req_op2), .req_rd(req_rd), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .alu_start(alu_start), .alu_code(alu_code),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
    .alu_done(alu_done), .busy(busy), .timeout_err(timeout_err),
    .bad_op_err(bad_op_err), .ops_issued(ops_issued), .cache_hits(cache_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected-output model state
  bit          chk_en;
  bit          m_busy, m_rv, m_start, m_drive, m_bad, m_tout;
  logic [5:0]  m_code;
  logic [31:0] m_op1, m_op2, m_data;
  logic [4:0]  m_rd;
  logic [31:0] m_ops, m_hits;
  bit          m_cv;
  logic [5:0]  m_ccode;
  logic [31:0] m_cop1, m_cop2, m_cdata;

  // Bench ALU controls
  bit alu_hang;
  int alu_lat;
  int alu_cnt;

  // Per-transaction measurement
  int cyc;
  int first_rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural M-extension results
  function automatic logic [31:0] mref(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa   = $signed(a);
    sb   = $signed(b);
    mref = '0;
    case (c)
      ALU_MUL:    begin up = {32'd0, a} * {32'd0, b}; mref = up[31:0]; end
      ALU_MULH:   begin sp = 64'(sa) * 64'(sb); mref = sp[63:32]; end
      ALU_MULHSU: begin sp = 64'(sa) * $signed({32'd0, b}); mref = sp[63:32]; end
      ALU_MULHU:  begin up = {32'd0, a} * {32'd0, b}; mref = up[63:32]; end
      ALU_DIV:    if (b == 32'd0) mref = 32'hFFFFFFFF;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) mref = a;
                  else mref = 32'(sa / sb);
      ALU_DIVU:   mref = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      ALU_REM:    if (b == 32'd0) mref = a;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) mref = 32'd0;
                  else mref = 32'(sa % sb);
      ALU_REMU:   mref = (b == 32'd0) ? a : a % b;
      default:    mref = 32'd0;
    endcase
  endfunction

  // Behavioural ALU: loads on the negedge where start is high, done after alu_lat negedges
  always @(negedge clk) begin
    if (alu_start) begin
      alu_result <= mref(alu_code, alu_op1, alu_op2);
      if (alu_hang) begin
        alu_done <= 1'b0;
        alu_cnt  <= 0;
      end else if (alu_lat == 0) begin
        alu_done <= 1'b1;
        alu_cnt  <= 0;
      end else begin
        alu_done <= 1'b0;
        alu_cnt  <= alu_lat;
      end
    end else if (alu_cnt > 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 1) alu_done <= 1'b1;
    end
  end

  // Compare DUT outputs with the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",        32'(busy),        32'(m_busy));
      chk("req_ready",   32'(req_ready),   32'(!m_busy && !flush));
      chk("resp_valid",  32'(resp_valid),  32'(m_rv && !flush));
      chk("alu_start",   32'(alu_start),   32'(m_start));
      chk("ops_issued",  ops_issued,       m_ops);
      chk("cache_hits",  cache_hits,       m_hits);
      chk("bad_op_err",  32'(bad_op_err),  32'(m_bad));
      chk("timeout_err", 32'(timeout_err), 32'(m_tout));
      if (m_rv) begin
        chk("resp_data", resp_data,    m_data);
        chk("resp_rd",   32'(resp_rd), 32'(m_rd));
      end
      if (m_drive) begin
        chk("alu_code", 32'(alu_code), 32'(m_code));
        chk("alu_op1",  alu_op1,       m_op1);
        chk("alu_op2",  alu_op2,       m_op2);
      end
    end
  end

  task automatic m_reset();
    m_busy = 0; m_rv = 0; m_start = 0; m_drive = 0; m_bad = 0; m_tout = 0;
    m_code = '0; m_op1 = '0; m_op2 = '0; m_data = '0; m_rd = '0;
    m_ops = '0; m_hits = '0;
    m_cv = 0; m_ccode = '0; m_cop1 = '0; m_cop2 = '0; m_cdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (resp_valid && first_rv < 0) first_rv = cyc;
  endtask

  // One request from presentation to response handshake; kill_w>0 kills it
  // in that WAIT cycle with flush (or rst when kill_rst is set)
  task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input int hold,
                        input int kill_w, input bit kill_rst, output logic [31:0] got);
    bit hit;
    bit tout;
    int kd;
    int kr;
    got      = '0;
    first_rv = -1;
    cyc      = -1;
    hit      = m_cv && (m_ccode == code) && (m_cop1 == a) && (m_cop2 == b);
    alu_lat  = lat;
    resp_ready  = (hold == 0);
    req_valid   = 1'b1;
    req_alucode = code;
    req_op1     = a;
    req_op2     = b;
    req_rd      = rd;
    step();
    req_valid = 1'b0;
    if (!is_mext(code)) begin
      m_bad = 1'b1;
      return;
    end
    m_busy = 1'b1;
    m_rd   = rd;
    if (hit) begin
      m_hits++;
      m_rv   = 1'b1;
      m_data = m_cdata;
    end else begin
      m_start = 1'b1; m_drive = 1'b1;
      m_code = code; m_op1 = a; m_op2 = b;
      kd   = alu_hang ? 1000000 : ((lat <= 1) ? 2 : lat + 1);
      tout = kd > TMO + 1;
      kr   = tout ? TMO + 1 : kd;
      step();
      m_start = 1'b0;
      m_ops++;
      while (cyc < kr) begin
        if (cyc == kill_w) begin
          if (kill_rst) begin
            rst = 1'b1;
            m_reset();
            #1;
            chk("rst_busy",       32'(busy),        32'd0);
            chk("rst_req_ready",  32'(req_ready),   32'd1);
            chk("rst_resp_valid", 32'(resp_valid),  32'd0);
            chk("rst_alu_start",  32'(alu_start),   32'd0);
            chk("rst_ops",        ops_issued,       32'd0);
            chk("rst_hits",       cache_hits,       32'd0);
            chk("rst_tout",       32'(timeout_err), 32'd0);
            chk("rst_bad",        32'(bad_op_err),  32'd0);
            chk("rst_resp_data",  resp_data,        32'd0);
            chk("rst_alu_op1",    alu_op1,          32'd0);
            step();
            rst = 1'b0;
          end else begin
            flush = 1'b1;
            step();
            flush   = 1'b0;
            m_busy  = 1'b0;
            m_drive = 1'b0;
          end
          return;
        end
        step();
      end
      m_drive = 1'b0;
      m_rv    = 1'b1;
      if (tout) begin
        m_data = '0;
        m_tout = 1'b1;
      end else begin
        m_data  = mref(code, a, b);
        m_cv    = 1'b1;
        m_ccode = code; m_cop1 = a; m_cop2 = b; m_cdata = m_data;
      end
    end
    for (int h = 0; h < hold; h++) step();
    resp_ready = 1'b1;
    got = resp_data;
    step();
    m_rv   = 1'b0;
    m_busy = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] exp;
    int          rv;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{ALU_MUL,    32'd7,        32'd6,        5'd3, 3, 32'd42,       4};
    vecs[1] = '{ALU_DIVU,   32'd100,      32'd0,        5'd4, 0, 32'hFFFFFFFF, 2};
    vecs[2] = '{ALU_DIV,    32'hFFFFFFEC, 32'd3,        5'd5, 3, 32'hFFFFFFFA, 4};
    vecs[3] = '{ALU_DIV,    32'hFFFFFFEC, 32'd3,        5'd6, 3, 32'hFFFFFFFA, 0};
    vecs[4] = '{ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd7, 0, 32'h80000000, 2};
    vecs[5] = '{ALU_REM,    32'h80000000, 32'hFFFFFFFF, 5'd8, 0, 32'd0,        2};
    vecs[6] = '{ALU_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd9, 3, 32'hFFFFFFFF, 4};
    vecs[7] = '{ALU_REM,    32'hFFFFFFF9, 32'd2,        5'd10, 3, 32'hFFFFFFFF, 4};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_alucode = '0;
    req_op1 = '0; req_op2 = '0; req_rd = '0; resp_ready = 1'b1;
    alu_hang = 1'b0; alu_lat = 0; alu_cnt = 0; alu_done = 1'b0; alu_result = '0;
    cyc = 0; first_rv = -1;
    m_reset();
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_ops",       ops_issued,     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed operations including minimum-latency, overflow and cache-hit cases
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].lat, 0, 0, 1'b0, got);
      chk($sformatf("vec%0d_data", i), got, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 32'(first_rv), 32'(vecs[i].rv));
    end
    chk("table_ops",  ops_issued, 32'd7);
    chk("table_hits", cache_hits, 32'd1);

    // Flush in the third WAIT cycle, then let the stale done rise
    run_op(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 20, 0, 3, 1'b0, got);
    chk("flush_no_resp", 32'(first_rv < 0), 32'd1);
    chk("flush_idle",    32'(busy),         32'd0);
    for (int i = 0; i < 30; i++) step();
    run_op(ALU_REMU, 32'd17, 32'd5, 5'd12, 3, 0, 0, 1'b0, got);
    chk("remu_data", got,          32'd2);
    chk("remu_lat",  32'(first_rv), 32'd4);
    chk("remu_ops",  ops_issued,    32'd9);

    // Backpressure: response held for five cycles
    run_op(ALU_MULH, 32'h80000000, 32'd2, 5'd17, 3, 5, 0, 1'b0, got);
    chk("hold_data", got,        32'hFFFFFFFF);
    chk("hold_idle", 32'(busy),  32'd0);

    // Non-M code is dropped
    run_op(ALU_ADD, 32'd1, 32'd2, 5'd1, 0, 0, 0, 1'b0, got);
    chk("bad_flag", 32'(bad_op_err), 32'd1);
    chk("bad_idle", 32'(busy),       32'd0);
    step();

    // Watchdog abort, then the same op must miss in the cache
    alu_hang = 1'b1;
    run_op(ALU_MUL, 32'd3, 32'd3, 5'd20, 0, 0, 0, 1'b0, got);
    chk("tout_data", got,              32'd0);
    chk("tout_lat",  32'(first_rv),    32'(TMO + 1));
    chk("tout_flag", 32'(timeout_err), 32'd1);
    alu_hang = 1'b0;
    run_op(ALU_MUL, 32'd3, 32'd3, 5'd21, 3, 0, 0, 1'b0, got);
    chk("retry_data", got,           32'd9);
    chk("retry_lat",  32'(first_rv), 32'd4);
    chk("retry_ops",  ops_issued,    32'd12);

    // Asynchronous reset in the middle of WAIT
    alu_hang = 1'b1;
    run_op(ALU_MUL, 32'd5, 32'd5, 5'd22, 0, 0, 2, 1'b1, got);
    alu_hang = 1'b0;
    run_op(ALU_MUL, 32'd7, 32'd6, 5'd3, 3, 0, 0, 1'b0, got);
    chk("post_rst_data", got,           32'd42);
    chk("post_rst_lat",  32'(first_rv), 32'd4);
    chk("post_rst_ops",  ops_issued,    32'd1);
    chk("post_rst_hits", cache_hits,    32'd0);
    step();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
